// File: rtl/vc_plane_arbiter.sv
// rtl/vc_plane_arbiter.sv - round-robin wormhole arbiter driving the VC plane select of the switch mux
module vc_plane_arbiter #(
  parameter int VC = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [VC-1:0]   vcRequest,
  input  logic [VC-1:0]   vcTail,
  input  logic            switchReady,
  output logic [VC:0]     VCPlaneSelector,
  output logic            planeValid,
  output logic [VC-1:0]   vcGrant,
  output logic            flitXfer
);

  localparam int SW = VC + 1;
  localparam int IW = (VC > 1) ? $clog2(VC) : 1;

  typedef enum logic {IDLE, LOCKED} stateType;

  stateType        state, nextState;
  logic [SW-1:0]   sel, nextSel;
  logic [SW-1:0]   rrPtr, nextPtr;
  logic [IW-1:0]   selIdx;
  logic [VC-1:0]   selMask;
  logic [VC-1:0]   otherReq;

  // First set bit of req, scanning upward from ptr+1 and wrapping modulo VC.
  function automatic logic [SW-1:0] rrPick(input logic [VC-1:0] req, input logic [SW-1:0] ptr);
    logic [SW-1:0] res;
    logic          found;
    logic [IW-1:0] idx;
    res   = '0;
    found = 1'b0;
    for (int k = 1; k <= VC; k++) begin
      idx = IW'((int'(ptr) + k) % VC);
      if (!found && req[idx]) begin
        found = 1'b1;
        res   = SW'(idx);
      end
    end
    return res;
  endfunction

  assign selIdx          = sel[IW-1:0];
  assign selMask         = VC'(1) << selIdx;
  assign otherReq        = vcRequest & ~selMask;
  assign planeValid      = (state == LOCKED);
  assign VCPlaneSelector = sel;
  assign vcGrant         = planeValid ? selMask : '0;
  assign flitXfer        = planeValid & vcRequest[selIdx] & switchReady;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= '0;
      rrPtr <= SW'(VC - 1);
    end else begin
      state <= nextState;
      sel   <= nextSel;
      rrPtr <= nextPtr;
    end
  end

  always_comb begin
    nextState = state;
    nextSel   = sel;
    nextPtr   = rrPtr;
    case (state)
      IDLE: begin
        if (|vcRequest) begin
          nextSel   = rrPick(vcRequest, rrPtr);
          nextState = LOCKED;
        end
      end
      LOCKED: begin
        // Lock releases only when the tail flit actually crosses the switch.
        if (flitXfer && vcTail[selIdx]) begin
          nextPtr = sel;
          if (|otherReq) begin
            nextSel = rrPick(otherReq, sel);
          end else if (!vcRequest[selIdx]) begin
            nextState = IDLE;
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vc_plane_arbiter.sv
// tb/tb_vc_plane_arbiter.sv - table-driven scoreboard bench for vc_plane_arbiter
module tb_vc_plane_arbiter;

  localparam int VC = 4;

  logic          clk;
  logic          rst;
  logic [VC-1:0] vcRequest;
  logic [VC-1:0] vcTail;
  logic          switchReady;
  logic [VC:0]   VCPlaneSelector;
  logic          planeValid;
  logic [VC-1:0] vcGrant;
  logic          flitXfer;

  vc_plane_arbiter #(.VC(VC)) dut (
    .clk(clk),
    .rst(rst),
    .vcRequest(vcRequest),
    .vcTail(vcTail),
    .switchReady(switchReady),
    .VCPlaneSelector(VCPlaneSelector),
    .planeValid(planeValid),
    .vcGrant(vcGrant),
    .flitXfer(flitXfer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [VC-1:0] req;
    logic [VC-1:0] tail;
    logic          rdy;
    int            sel;
    logic          valid;
    logic          xfer;
  } vecT;

  typedef struct {
    int            row;
    logic [VC:0]   sel;
    logic          valid;
    logic [VC-1:0] grant;
    logic          xfer;
  } expT;

  expT sb[$];
  int  checks   = 0;
  int  failures = 0;
  int  rowNum   = 0;

  task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0h required=%0h", name, row, act, req);
    end
  endtask

  // Expected outputs hold for the cycle in which the row's inputs are applied.
  task automatic step(input logic r, input logic [VC-1:0] req, input logic [VC-1:0] tail,
                      input logic rdy, input int eSel, input logic eValid, input logic eXfer);
    expT e;
    @(posedge clk);
    #1;
    rst         = r;
    vcRequest   = req;
    vcTail      = tail;
    switchReady = rdy;
    e.row   = rowNum;
    e.sel   = (VC+1)'(eSel);
    e.valid = eValid;
    e.grant = eValid ? (VC'(1) << eSel) : '0;
    e.xfer  = eXfer;
    sb.push_back(e);
    rowNum++;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      expT e;
      e = sb.pop_front();
      check("sel",   e.row, 32'(VCPlaneSelector), 32'(e.sel));
      check("valid", e.row, 32'(planeValid),      32'(e.valid));
      check("grant", e.row, 32'(vcGrant),         32'(e.grant));
      check("xfer",  e.row, 32'(flitXfer),        32'(e.xfer));
    end
  end

  vecT vecs[$];

  function automatic vecT mk(input logic r, input logic [VC-1:0] req, input logic [VC-1:0] tail,
                             input logic rdy, input int s, input logic v, input logic x);
    vecT t;
    t.rst = r; t.req = req; t.tail = tail; t.rdy = rdy;
    t.sel = s; t.valid = v; t.xfer = x;
    return t;
  endfunction

  initial begin
    rst = 1'b1;
    vcRequest = '0;
    vcTail = '0;
    switchReady = 1'b0;

    // reset state, then grant on plane 2 at n+1
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 2, 1, 0));
    // plane 2 alone: back-to-back packets re-grant with no gap
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 1, 2, 1, 1));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 1, 2, 1, 1));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 1, 2, 1, 1));
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 0, 2, 1, 0));
    // plane 1, 3-flit packet with all planes requesting
    vecs.push_back(mk(0, 4'b0010, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 1, 1, 1));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 1, 1, 1));
    vecs.push_back(mk(0, 4'b1111, 4'b0010, 1, 1, 1, 1));
    // single-flit packets rotate 2,3,0,1,2 with no gaps
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 2, 1, 1));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 3, 1, 1));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 1, 1));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 1, 1, 1));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 2, 1, 1));
    // plane 3 stalled and bubbled while plane 0 waits
    vecs.push_back(mk(0, 4'b1001, 4'b1000, 0, 3, 1, 0));
    vecs.push_back(mk(0, 4'b0001, 4'b1000, 0, 3, 1, 0));
    vecs.push_back(mk(0, 4'b0001, 4'b1000, 0, 3, 1, 0));
    vecs.push_back(mk(0, 4'b1001, 4'b1000, 0, 3, 1, 0));
    vecs.push_back(mk(0, 4'b1001, 4'b1000, 0, 3, 1, 0));
    vecs.push_back(mk(0, 4'b0001, 4'b1111, 1, 3, 1, 0));
    vecs.push_back(mk(0, 4'b1001, 4'b0000, 1, 3, 1, 1));
    vecs.push_back(mk(0, 4'b1001, 4'b1000, 1, 3, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 1, 0));
    // reset mid-packet on plane 1, then 1010 grants plane 1
    vecs.push_back(mk(0, 4'b0011, 4'b0001, 1, 0, 1, 1));
    vecs.push_back(mk(0, 4'b0010, 4'b0000, 1, 1, 1, 1));
    vecs.push_back(mk(1, 4'b0010, 4'b0000, 1, 1, 1, 1));
    vecs.push_back(mk(0, 4'b1010, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 1, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 1, 0));

    repeat (2) @(posedge clk);
    foreach (vecs[i])
      step(vecs[i].rst, vecs[i].req, vecs[i].tail, vecs[i].rdy, vecs[i].sel, vecs[i].valid, vecs[i].xfer);

    // after reset a lone request on the top plane wraps the pointer scan to plane 3
    step(1, 4'b0000, 4'b0000, 0, 1, 1, 0);
    step(0, 4'b1000, 4'b0000, 0, 0, 0, 0);
    step(0, 4'b0000, 4'b0000, 1, 3, 1, 0);
    step(0, 4'b1000, 4'b0000, 1, 3, 1, 1);

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
